keypad_onehot_debouncer: RTL and testbench

//  Front end for the 10-key decimal keypad. Synchronises and debounces raw key lines,

---
 rtl/keypad_onehot_debouncer_pkg.sv | 21 ++
 rtl/keypad_onehot_debouncer_sync_2ff.sv | 23 ++
 rtl/keypad_onehot_debouncer.sv | 100 ++++++++++
 tb/tb_keypad_onehot_debouncer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_onehot_debouncer_pkg.sv
// Shared keypad definitions: key count, FSM state encoding and the one-hot test
// used when deciding whether a synchronised key pattern is a single press.
package keypad_pkg;

  localparam int KEY_W = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [KEY_W-1:0] KEY_ONE = {{(KEY_W-1){1'b0}}, 1'b1};

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_ONE)) == '0);
  endfunction

endpackage

// File: rtl/keypad_onehot_debouncer_sync_2ff.sv
// Two-stage synchroniser with asynchronous active-low clear, one flop pair per bit.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_onehot_debouncer.sv
// Keypad front end: synchronises raw key lines, debounces single-key presses and
// releases, rejects multi-key presses and presents a registered one-hot key code.
module keypad_onehot_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] keys_raw,
  output logic [KEY_W-1:0] key_onehot,
  output logic             key_strobe,
  output logic             key_held,
  output logic             multi_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [KEY_W-1:0] s;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  state_t           state;

  sync_2ff #(.W(KEY_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (keys_raw),
    .q     (s)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

  // A change of s always wins over a counter reaching its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      key_onehot <= '0;
      key_strobe <= 1'b0;
      key_held   <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      multi_err  <= 1'b0;
      case (state)
        IDLE: begin
          key_onehot <= '0;
          key_held   <= 1'b0;
          if (is_onehot(s)) begin
            cand  <= s;
            cnt   <= '0;
            state <= DEBOUNCE;
          end else if (s != '0) begin
            multi_err <= 1'b1;
            cnt       <= '0;
            state     <= RELEASE;
          end
        end
        DEBOUNCE: begin
          if (s != cand) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt == CNT_LAST) begin
              key_onehot <= cand;
              key_strobe <= 1'b1;
              key_held   <= 1'b1;
              state      <= PRESSED;
            end
          end
        end
        PRESSED: begin
          if (s != cand) begin
            key_onehot <= '0;
            key_held   <= 1'b0;
            cnt        <= '0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          key_onehot <= '0;
          key_held   <= 1'b0;
          if (s != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_onehot_debouncer.sv
// Directed bench for keypad_onehot_debouncer with a 4-cycle debounce, a BCD encoder
// model on key_onehot and a queue of expected output snapshots.
module tb_keypad_onehot_debouncer;

  logic       clk;
  logic       rst_n;
  logic [9:0] keys_raw;
  logic [9:0] key_onehot;
  logic       key_strobe;
  logic       key_held;
  logic       multi_err;

  typedef struct {
    string      tag;
    logic [9:0] onehot;
    logic       strobe;
    logic       held;
    logic       merr;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert;
  int   n_fail;
  int   strobe_count;
  int   merr_count;
  int   base;

  keypad_onehot_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys_raw   (keys_raw),
    .key_onehot (key_onehot),
    .key_strobe (key_strobe),
    .key_held   (key_held),
    .multi_err  (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe === 1'b1) strobe_count++;
    if (multi_err === 1'b1) merr_count++;
  end

  // Downstream decimal-to-BCD encoder: any non one-hot input encodes as 0.
  function automatic int bcd_of(input logic [9:0] d);
    int y;
    y = 0;
    for (int k = 0; k < 10; k++)
      if (d == (10'd1 << k)) y = k;
    return y;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [9:0] k);
    keys_raw = k;
  endtask

  task automatic expect_out(input string tag, input logic [9:0] oh, input logic st,
                            input logic hd, input logic me);
    exp_t e;
    e.tag = tag; e.onehot = oh; e.strobe = st; e.held = hd; e.merr = me;
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e = exp_q.pop_front();
    n_assert++;
    assert (key_onehot === e.onehot) else begin
      n_fail++;
      $error("FAIL %s.key_onehot: observed %h expected %h", e.tag, key_onehot, e.onehot);
    end
    n_assert++;
    assert (key_strobe === e.strobe) else begin
      n_fail++;
      $error("FAIL %s.key_strobe: observed %b expected %b", e.tag, key_strobe, e.strobe);
    end
    n_assert++;
    assert (key_held === e.held) else begin
      n_fail++;
      $error("FAIL %s.key_held: observed %b expected %b", e.tag, key_held, e.held);
    end
    n_assert++;
    assert (multi_err === e.merr) else begin
      n_fail++;
      $error("FAIL %s.multi_err: observed %b expected %b", e.tag, multi_err, e.merr);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    strobe_count = 0;
    merr_count   = 0;
    rst_n        = 1'b0;
    apply_stimulus(10'h010);

    // 1: reset with key held, then press accepted 7 edges after release
    tick(3);
    expect_out("t1_reset", 10'h000, 0, 0, 0); check_output();
    rst_n = 1'b1;
    tick(6);
    expect_out("t1_pre", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t1_strobe", 10'h010, 1, 1, 0); check_output();
    check_val("t1_bcd", bcd_of(key_onehot), 4);
    tick(1);
    expect_out("t1_hold", 10'h010, 0, 1, 0); check_output();

    apply_stimulus(10'h000);
    tick(2);
    expect_out("t1_rel_pre", 10'h010, 0, 1, 0); check_output();
    tick(1);
    expect_out("t1_rel", 10'h000, 0, 0, 0); check_output();
    tick(10);

    // 2: long press gives exactly one strobe and key_held throughout
    base = strobe_count;
    apply_stimulus(10'h020);
    tick(6);
    expect_out("t2_pre", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t2_strobe", 10'h020, 1, 1, 0); check_output();
    for (int i = 0; i < 23; i++) begin
      tick(1);
      expect_out("t2_hold", 10'h020, 0, 1, 0); check_output();
    end
    check_val("t2_strobes", strobe_count - base, 1);
    apply_stimulus(10'h000);
    tick(2);
    expect_out("t2_rel_pre", 10'h020, 0, 1, 0); check_output();
    tick(1);
    expect_out("t2_rel", 10'h000, 0, 0, 0); check_output();
    check_val("t2_bcd_zero", bcd_of(key_onehot), 0);
    tick(10);

    // 3: bouncing key, then settle
    base = strobe_count;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(10'h004);
      tick(2);
      apply_stimulus(10'h000);
      tick(2);
    end
    check_val("t3_bounce_strobes", strobe_count - base, 0);
    apply_stimulus(10'h004);
    tick(6);
    expect_out("t3_pre", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t3_strobe", 10'h004, 1, 1, 0); check_output();
    check_val("t3_bcd", bcd_of(key_onehot), 2);
    apply_stimulus(10'h000);
    tick(12);

    // 4: two keys at once flag an error and are never accepted
    base = strobe_count;
    apply_stimulus(10'h003);
    tick(2);
    expect_out("t4_pre", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t4_merr", 10'h000, 0, 0, 1); check_output();
    tick(1);
    expect_out("t4_merr_end", 10'h000, 0, 0, 0); check_output();
    tick(8);
    check_val("t4_merr_count", merr_count, 1);
    check_val("t4_no_strobe", strobe_count - base, 0);
    apply_stimulus(10'h000);
    tick(12);
    apply_stimulus(10'h200);
    tick(6);
    expect_out("t4_pre9", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t4_strobe9", 10'h200, 1, 1, 0); check_output();
    check_val("t4_bcd", bcd_of(key_onehot), 9);
    apply_stimulus(10'h000);
    tick(12);

    // 5: extra key while pressed drops the key; re-press needs 4 quiet cycles
    apply_stimulus(10'h008);
    tick(7);
    expect_out("t5_strobe", 10'h008, 1, 1, 0); check_output();
    tick(2);
    base = strobe_count;
    apply_stimulus(10'h00C);
    tick(2);
    expect_out("t5_extra_pre", 10'h008, 0, 1, 0); check_output();
    tick(1);
    expect_out("t5_extra", 10'h000, 0, 0, 0); check_output();
    apply_stimulus(10'h000);
    tick(2);
    apply_stimulus(10'h008);
    tick(12);
    expect_out("t5_short_quiet", 10'h000, 0, 0, 0); check_output();
    check_val("t5_no_strobe", strobe_count - base, 0);
    apply_stimulus(10'h000);
    tick(4);
    apply_stimulus(10'h008);
    tick(6);
    expect_out("t5_pre", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t5_restrobe", 10'h008, 1, 1, 0); check_output();
    check_val("t5_bcd", bcd_of(key_onehot), 3);
    apply_stimulus(10'h000);
    tick(12);

    // 6: reset mid-debounce and mid-press
    apply_stimulus(10'h100);
    tick(5);
    rst_n = 1'b0;
    #1;
    expect_out("t6_reset_deb", 10'h000, 0, 0, 0); check_output();
    tick(2);
    rst_n = 1'b1;
    tick(6);
    expect_out("t6_pre", 10'h000, 0, 0, 0); check_output();
    tick(1);
    expect_out("t6_strobe", 10'h100, 1, 1, 0); check_output();
    check_val("t6_bcd", bcd_of(key_onehot), 8);
    tick(2);
    rst_n = 1'b0;
    #1;
    expect_out("t6_reset_pressed", 10'h000, 0, 0, 0); check_output();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_val("t6_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
